// File: rtl/mmcm_drp_reconfig.sv
// Run-time MMCM retuning sequencer: holds the MMCM in reset, read-modify-writes each DRP
// table entry of the selected configuration, releases reset and waits for LOCKED.
// Optional macro MMCM_DRP_READBACK_EN adds a verify read after every write.
module mmcm_drp_reconfig #(
    parameter int NUM_CFG      = 2,
    parameter int NUM_ENTRIES  = 23,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reconfig_req_i,
    input  logic [((NUM_CFG > 1) ? $clog2(NUM_CFG) : 1)-1:0] cfg_sel_i,
    output logic busy_o,
    output logic done_o,
    output logic error_o,
    output logic [((NUM_CFG > 1) ? $clog2(NUM_CFG) : 1)-1:0] tbl_cfg_o,
    output logic [((NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1)-1:0] tbl_entry_o,
    input  logic [6:0]  tbl_addr_i,
    input  logic [15:0] tbl_mask_i,
    input  logic [15:0] tbl_data_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        mmcm_rst_o,
    input  logic        mmcm_locked_i,
    output logic        clk_ok_o
);

    localparam int ENT_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int TMO_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int LCK_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, RST_ON, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT,
        VF_REQ, VF_WAIT, NEXT, RST_OFF, LOCK_WAIT
    } state_t;

    state_t             state_r;
    logic [15:0]        rd_data_r;
    logic [TMO_W-1:0]   tmo_r;
    logic [LCK_W-1:0]   lock_cnt_r;
    logic               abort_r;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            rd_data_r   <= 16'h0000;
            tmo_r       <= '0;
            lock_cnt_r  <= '0;
            abort_r     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            tbl_cfg_o   <= '0;
            tbl_entry_o <= '0;
            drp_den_o   <= 1'b0;
            drp_dwe_o   <= 1'b0;
            drp_daddr_o <= 7'h00;
            drp_di_o    <= 16'h0000;
            mmcm_rst_o  <= 1'b0;
            clk_ok_o    <= 1'b0;
        end else begin
            drp_den_o <= 1'b0;
            drp_dwe_o <= 1'b0;
            done_o    <= 1'b0;
            clk_ok_o  <= mmcm_locked_i & ~mmcm_rst_o & (state_r == IDLE);
            case (state_r)
                IDLE: begin
                    if (reconfig_req_i) begin
                        tbl_cfg_o   <= cfg_sel_i;
                        tbl_entry_o <= '0;
                        abort_r     <= 1'b0;
                        if (int'(cfg_sel_i) >= NUM_CFG) begin
                            error_o <= 1'b1;
                        end else begin
                            error_o  <= 1'b0;
                            busy_o   <= 1'b1;
                            // Drop clock-good on the accepting edge, not one cycle later
                            clk_ok_o <= 1'b0;
                            state_r  <= RST_ON;
                        end
                    end
                end
                RST_ON: begin
                    mmcm_rst_o <= 1'b1;
                    state_r    <= RD_REQ;
                end
                RD_REQ: begin
                    drp_den_o   <= 1'b1;
                    drp_daddr_o <= tbl_addr_i;
                    tmo_r       <= '0;
                    state_r     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (drp_drdy_i) begin
                        rd_data_r <= drp_do_i;
                        state_r   <= WR_REQ;
                    end else if (tmo_r == TMO_W'(DRDY_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        abort_r <= 1'b1;
                        state_r <= RST_OFF;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                WR_REQ: begin
                    drp_den_o   <= 1'b1;
                    drp_dwe_o   <= 1'b1;
                    drp_daddr_o <= tbl_addr_i;
                    drp_di_o    <= (rd_data_r & tbl_mask_i) | (tbl_data_i & ~tbl_mask_i);
                    tmo_r       <= '0;
                    state_r     <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (drp_drdy_i) begin
`ifdef MMCM_DRP_READBACK_EN
                        state_r <= VF_REQ;
`else
                        state_r <= NEXT;
`endif
                    end else if (tmo_r == TMO_W'(DRDY_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        abort_r <= 1'b1;
                        state_r <= RST_OFF;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
`ifdef MMCM_DRP_READBACK_EN
                VF_REQ: begin
                    drp_den_o   <= 1'b1;
                    drp_daddr_o <= tbl_addr_i;
                    tmo_r       <= '0;
                    state_r     <= VF_WAIT;
                end
                VF_WAIT: begin
                    // drp_di_o still holds the value just written
                    if (drp_drdy_i) begin
                        if (drp_do_i != drp_di_o) begin
                            error_o <= 1'b1;
                            abort_r <= 1'b1;
                            state_r <= RST_OFF;
                        end else begin
                            state_r <= NEXT;
                        end
                    end else if (tmo_r == TMO_W'(DRDY_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        abort_r <= 1'b1;
                        state_r <= RST_OFF;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
`endif
                NEXT: begin
                    if (tbl_entry_o == ENT_W'(NUM_ENTRIES - 1)) begin
                        tbl_entry_o <= '0;
                        state_r     <= RST_OFF;
                    end else begin
                        tbl_entry_o <= tbl_entry_o + ENT_W'(1);
                        state_r     <= RD_REQ;
                    end
                end
                RST_OFF: begin
                    mmcm_rst_o <= 1'b0;
                    lock_cnt_r <= '0;
                    if (abort_r) begin
                        abort_r     <= 1'b0;
                        tbl_entry_o <= '0;
                        busy_o      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= LOCK_WAIT;
                    end
                end
                LOCK_WAIT: begin
                    // The first two cycles may still show LOCKED from before the reset
                    if ((lock_cnt_r >= LCK_W'(2)) && mmcm_locked_i) begin
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end else if (lock_cnt_r == LCK_W'(LOCK_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + LCK_W'(1);
                    end
                end
                default: begin
                    mmcm_rst_o <= 1'b0;
                    busy_o     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule
